// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared state encoding, operand/result widths and sizing helpers
// for the round-robin multiplier scheduler.
package mul_sched_pkg;

  localparam int OP_W  = 4;
  localparam int RES_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_t;

  // The latency counter only has to reach lat-1; keep at least one bit.
  function automatic int cnt_w(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request bit at or
// above ptr, wrapping; returns a one-hot grant, its index and an any-request flag.
module rr_arbiter import mul_sched_pkg::*; #(
  parameter int NREQ = 4,
  localparam int IW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int   j;
    logic hit;
    j   = 0;
    hit = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!hit && req[j]) begin
        hit    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
    any = hit;
  end

endmodule

// File: rtl/mul_sched.sv
// mul_sched: shares one fixed-latency 4x4 shift-add multiplier among NREQ requesters.
// Build option MUL_SCHED_ZERO_BYPASS_EN answers zero-operand requests without the multiplier.
module mul_sched import mul_sched_pkg::*; #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [OP_W*NREQ-1:0] req_a,
  input  logic [OP_W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [RES_W-1:0]     rsp_p,
  output logic                 mul_start,
  output logic [OP_W-1:0]      mul_a,
  output logic [OP_W-1:0]      mul_b,
  input  logic [RES_W-1:0]     mul_op,
  output logic                 busy
);

  localparam int            IW       = idx_w(NREQ);
  localparam int            CW       = cnt_w(MUL_LAT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

  state_t           state, nstate;
  logic [IW-1:0]    ptr, gidx, arb_idx;
  logic [NREQ-1:0]  arb_gnt;
  logic             arb_any;
  logic [CW-1:0]    cnt;
  logic [RES_W-1:0] result;
  op_t              op, op_in;
  logic             zero_op;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign op_in.a = req_a[OP_W*int'(arb_idx) +: OP_W];
  assign op_in.b = req_b[OP_W*int'(arb_idx) +: OP_W];

`ifdef MUL_SCHED_ZERO_BYPASS_EN
  assign zero_op = (op_in.a == '0) || (op_in.b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Every handshake-facing strobe is gated by reset so an abort emits nothing.
  always_comb begin
    nstate    = state;
    req_ready = '0;
    rsp_valid = '0;
    mul_start = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            req_ready = arb_gnt;
            nstate    = zero_op ? RESP : ISSUE;
          end
        end
        ISSUE: begin
          mul_start = 1'b1;
          nstate    = WAIT;
        end
        WAIT: begin
          if (cnt == CNT_LAST) nstate = RESP;
        end
        RESP: begin
          rsp_valid[gidx] = 1'b1;
          nstate          = IDLE;
        end
        default: nstate = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      gidx   <= '0;
      cnt    <= '0;
      result <= '0;
      op     <= '0;
    end else begin
      state <= nstate;
      case (state)
        IDLE: begin
          if (arb_any) begin
            op   <= op_in;
            gidx <= arb_idx;
            if (zero_op) result <= '0;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) result <= mul_op;
        end
        // Advancing past the served requester gives everyone else priority next.
        RESP: ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
        default: ;
      endcase
    end
  end

  assign busy  = !reset && (state != IDLE);
  assign mul_a = op.a;
  assign mul_b = op.b;
  assign rsp_p = result;

endmodule
